config_loader: RTL
==================

# config_loader

Bitstream loader sitting directly upstream of the fabric's configuration shift register. It accepts configuration words from a host over a valid/ready stream and serializes them, LSB first, onto the shift register's serial input with a per-bit enable. It counts exactly CONFIG_LENGTH bits and holds the user fabric in reset for the whole load. Once the last bit is shifted, it releases the fabric and flags completion.

## Interface
- CONFIG_LENGTH, 42368: total configuration bits to shift; must equal the shift register length.
- WORD_WIDTH, 8: host word width, ≥1.
- config_clock  in  1  single clock; also clocks the downstream shift register.
- config_nreset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled in IDLE or DONE only.
- abort  in  1  cancel an in-progress load.
- data_in  in  WORD_WIDTH  configuration word.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  loader accepts data_in this cycle.
- config_bit  out  1  serial bit to the shift register's config_in.
- config_enable  out  1  shift-enable to the shift register.
- core_nreset  out  1  active-low reset for the user fabric; low while unconfigured or loading.
- busy  out  1  load in progress (FETCH or SHIFT).
- done  out  1  full bitstream shifted; fabric released.

## Operation
- States: IDLE, FETCH, SHIFT, DONE. Reset state is IDLE.
- Registers: word_reg[WORD_WIDTH], bit_in_word counter (0..WORD_WIDTH-1), bit_count counter of width $clog2(CONFIG_LENGTH+1).
- IDLE: data_ready=0, config_enable=0, core_nreset=0. When start=1, clear bit_count and go to FETCH.
- FETCH: data_ready=1. On data_valid & data_ready, load word_reg=data_in, clear bit_in_word, and go to SHIFT.
- SHIFT: config_enable=1 and config_bit=word_reg[0] every cycle. At each edge, shift word_reg right by one, increment bit_in_word and bit_count.
  - If bit_count+1 == CONFIG_LENGTH, go to DONE; this takes priority.
  - Else if bit_in_word == WORD_WIDTH-1, go to FETCH.
  - Else stay in SHIFT.
- DONE: core_nreset=1, done=1. When start=1, clear bit_count, drive core_nreset=0, and go to FETCH (reload).
- abort=1 in FETCH or SHIFT returns to IDLE next cycle. Any partial word is discarded and core_nreset stays 0. abort has priority over the handshake and the shift. abort is ignored in IDLE and DONE.
- start is ignored in FETCH and SHIFT.
- If CONFIG_LENGTH is not a multiple of WORD_WIDTH, the upper bits of the final word are never emitted. No further word is requested.
- busy = (state==FETCH or SHIFT). done = (state==DONE).
- config_bit, config_enable and data_ready are decoded directly from state/word_reg flops, with no input-to-output combinational path.
- config_bit is 0 whenever config_enable=0.

## Timing
- Reset values: data_ready=0, config_bit=0, config_enable=0, core_nreset=0, busy=0, done=0. Counters and word_reg are 0.
- start high at edge N: data_ready=1 from cycle N+1.
- Handshake at edge M: the first bit appears with config_enable=1 during cycle M+1 and is captured by the shift register at edge M+2.
- A full word occupies WORD_WIDTH consecutive enable cycles, followed by at least one FETCH cycle (data_ready=1).
- Throughput is WORD_WIDTH+1 cycles per word with continuous valid.
- Last enable cycle is K: state is DONE in cycle K+1, with config_enable=0, done=1, core_nreset=1.
- config_enable is high for exactly CONFIG_LENGTH cycles per completed load.
- Reset asserted mid-load: all outputs go to their reset values immediately (asynchronously). After reset, a new start is required.
- data_valid low in FETCH: the loader waits indefinitely with config_enable=0 and no bit consumed.

## Test plan
- CONFIG_LENGTH=20, WORD_WIDTH=8; start, then words 0xA5, 0x3C, 0xFF with valid held high:
  - config_bit sequence over 20 enable cycles is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1.
  - Exactly 3 handshakes occur, then done=1 and core_nreset=1.
- Default parameters, 5296 random words: count exactly 42368 enable cycles. A model shift register's contents equal the expected bitstream, and its config_out tap equals bit 0 of word 0.
- data_valid toggled randomly (50%): same 20-bit stream as the first case. No enable pulses while in FETCH. data_ready never asserted outside FETCH.
- abort asserted on the 3rd bit of the 2nd word: next cycle IDLE, busy=0, done=0, core_nreset=0. A subsequent start and full load succeeds with the correct stream.
- config_nreset pulsed low mid-SHIFT: outputs go to reset values asynchronously. start asserted during a load is ignored. start asserted in DONE drops core_nreset to 0 and reloads.

Source files
------------

// File: rtl/config_loader.sv
// Configuration bitstream loader: takes host words over valid/ready, shifts them
// LSB first into the fabric's configuration chain and holds the fabric in reset until done.
module config_loader #(
  parameter int CONFIG_LENGTH = 42368,
  parameter int WORD_WIDTH    = 8
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  config_bit,
  output logic                  config_enable,
  output logic                  core_nreset,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int CNT_W = $clog2(CONFIG_LENGTH + 1);
  localparam int BIW_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(CONFIG_LENGTH - 1);
  localparam logic [BIW_W-1:0] LAST_IN_WORD = BIW_W'(WORD_WIDTH - 1);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [BIW_W-1:0]      bit_in_word_q, bit_in_word_d;
  logic [CNT_W-1:0]      bit_count_q, bit_count_d;

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state_q       <= S_IDLE;
      word_q        <= '0;
      bit_in_word_q <= '0;
      bit_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      bit_in_word_q <= bit_in_word_d;
      bit_count_q   <= bit_count_d;
    end
  end

  // Handshake: a word moves when data_valid && data_ready are both high at the
  // rising edge; data_ready depends only on state, never on data_valid.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    bit_in_word_d = bit_in_word_q;
    bit_count_d   = bit_count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bit_count_d = '0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          word_d  = '0;
          state_d = S_IDLE;
        end else if (data_valid) begin
          word_d        = data_in;
          bit_in_word_d = '0;
          state_d       = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          word_d  = '0;
          state_d = S_IDLE;
        end else begin
          word_d        = word_q >> 1;
          bit_in_word_d = bit_in_word_q + BIW_W'(1);
          bit_count_d   = bit_count_q + CNT_W'(1);
          // The final bit wins even mid-word: leftover upper bits are dropped.
          if (bit_count_q == LAST_BIT) begin
            state_d = S_DONE;
          end else if (bit_in_word_q == LAST_IN_WORD) begin
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          bit_count_d = '0;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_ready    = 1'b0;
    config_bit    = 1'b0;
    config_enable = 1'b0;
    core_nreset   = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_FETCH: begin
        data_ready = 1'b1;
        busy       = 1'b1;
      end
      S_SHIFT: begin
        config_enable = 1'b1;
        config_bit    = word_q[0];
        busy          = 1'b1;
      end
      S_DONE: begin
        core_nreset = 1'b1;
        done        = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule
